snake_dir_queue: RTL and testbench
==================================

// Module: snake_dir_queue
// PURPOSE
//   Direction controller for the snake game that buffers steering input.
//   Button presses are edge-detected, validated and queued, so fast
//   multi-key turns taken between two game ticks are not lost.
//   One queued direction is applied per game tick. Sits between the
//   debounced button inputs and the snake movement/body logic.
// PARAMETERS
//   QUEUE_DEPTH  2  max pending turns (>=1); count width = $clog2(QUEUE_DEPTH+1)
// PORTS
//   clk           in   1   system clock
//   reset         in   1   synchronous, active-high reset
//   up            in   1   up button (debounced, level)
//   down          in   1   down button
//   left          in   1   left button
//   right         in   1   right button
//   tick          in   1   1-cycle game-step strobe; pops one queued turn
//   direction     out  3   applied dir: 000 idle, 001 up, 010 down, 011 left, 100 right
//   dir_changed   out  1   1-cycle pulse: direction updated this cycle
//   queue_count   out  CW  entries pending (CW = $clog2(QUEUE_DEPTH+1))
//   overflow      out  1   1-cycle pulse: valid press dropped, queue full
// BEHAVIOUR
//   Reset
//   - direction=IDLE, queue empty, queue_count=0, dir_changed=0, overflow=0.
//   - Button history registers load the current button levels during reset,
//     so a button held through reset creates no press.
//   Press detection
//   - press_x = x & ~x_q (rising edge only). Holding a button never repeats.
//   - Several edges in one cycle: accept only the highest priority
//     (up > down > left > right); the rest are discarded.
//   Validation against ref_dir
//   - ref_dir = queue tail entry if the queue is non-empty, else direction.
//   - Reject the press if dir == ref_dir (duplicate) or dir == opposite(ref_dir).
//   - Opposite pairs: up/down, left/right. From IDLE, every dir is accepted.
//   - A rejected press has no effect: no overflow, no enqueue.
//   Queue
//   - FIFO of QUEUE_DEPTH x 3-bit entries.
//   - Valid press with queue full (and no pop this cycle): drop it,
//     overflow=1 next cycle.
//   - tick with queue non-empty: pop head; direction=head and
//     dir_changed=1 on the next cycle (1-cycle latency).
//   - tick with queue empty: direction holds, dir_changed stays 0.
//   - Same-cycle push and pop: both happen; count is unchanged; a full
//     queue accepts the push (no overflow).
//   - ref_dir in that cycle is the pre-pop tail, even if that entry is the
//     one being popped.
//   - Press and tick together on an empty queue: the press is enqueued.
//     There is no bypass; it applies on the following tick.
//   - Pointers wrap modulo QUEUE_DEPTH. queue_count never exceeds
//     QUEUE_DEPTH and never underflows.
//   - reset asserted mid-operation: the queue is flushed the next cycle
//     and any pending pulse is cleared.
// STRUCTURE
//   - snake_pkg: localparams DIR_IDLE/UP/DOWN/LEFT/RIGHT, DIR_W=3, and
//     function dir_opposite(dir) returning the opposite encoding
//     (IDLE -> IDLE). Shared with the movement and render logic.
//   - Sub-module snake_dir_fifo (WIDTH, DEPTH): sync FIFO with push, pop,
//     full, empty, count, head, tail. Push-when-full and pop-when-empty
//     are ignored; push+pop when full is allowed.
//   - Top level: edge detect, priority select, validation, direction register.
// TESTING
//   1. Reset with up held, release, no tick
//      -> queue_count=0, direction=000; then press right -> count=1.
//   2. IDLE, press up, tick
//      -> cycle after tick: direction=001, dir_changed=1 for exactly 1 cycle.
//   3. direction=up; press left, then down, in one tick window; two ticks
//      -> direction 011 then 010 (down validated against tail=left).
//   4. direction=right, press left -> rejected (count stays 0);
//      press right -> rejected as duplicate.
//   5. QUEUE_DEPTH=2, dir=up: press left, down, right -> third press
//      dropped, overflow pulse, count=2. Repeat the third press on a tick
//      cycle -> accepted, count stays 2.
//   6. up+left edges in the same cycle from IDLE -> only up queued;
//      tick on an empty queue -> no dir_changed.

Source files
------------

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction encodings and helpers for the snake game
package snake_pkg;

   localparam int DIR_W = 3;

   localparam logic [DIR_W-1:0] DIR_IDLE  = 3'd0;
   localparam logic [DIR_W-1:0] DIR_UP    = 3'd1;
   localparam logic [DIR_W-1:0] DIR_DOWN  = 3'd2;
   localparam logic [DIR_W-1:0] DIR_LEFT  = 3'd3;
   localparam logic [DIR_W-1:0] DIR_RIGHT = 3'd4;

   // Reverse heading; IDLE has no opposite and maps to itself.
   function automatic logic [DIR_W-1:0] dir_opposite(input logic [DIR_W-1:0] dir);
      logic [DIR_W-1:0] opp;
      case (dir)
         DIR_UP:    opp = DIR_DOWN;
         DIR_DOWN:  opp = DIR_UP;
         DIR_LEFT:  opp = DIR_RIGHT;
         DIR_RIGHT: opp = DIR_LEFT;
         default:   opp = DIR_IDLE;
      endcase
      return opp;
   endfunction

endpackage

// File: rtl/snake_dir_fifo.sv
// rtl/snake_dir_fifo.sv - small synchronous FIFO holding pending turns
module snake_dir_fifo
   import snake_pkg::*;
#(
   parameter int WIDTH = DIR_W,
   parameter int DEPTH = 2,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count,
   output logic [WIDTH-1:0] head,
   output logic [WIDTH-1:0] tail
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    tail_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
      return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_push  = push && (!full || (pop && !empty));
   assign do_pop   = pop && !empty;
   assign tail_ptr = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - 1'b1;
   assign head     = mem[rd_ptr];
   assign tail     = mem[tail_ptr];

   // Storage array; contents are only meaningful while count covers them.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_next(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/snake_dir_queue.sv
// rtl/snake_dir_queue.sv - buffered steering input for the snake game
module snake_dir_queue
   import snake_pkg::*;
#(
   parameter int QUEUE_DEPTH = 2,
   localparam int CW = $clog2(QUEUE_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             up,
   input  logic             down,
   input  logic             left,
   input  logic             right,
   input  logic             tick,
   output logic [DIR_W-1:0] direction,
   output logic             dir_changed,
   output logic [CW-1:0]    queue_count,
   output logic             overflow
);

   logic [3:0]       btn;
   logic [3:0]       btn_q;
   logic [3:0]       press;
   logic [DIR_W-1:0] press_dir;
   logic [DIR_W-1:0] ref_dir;
   logic [DIR_W-1:0] fifo_head;
   logic [DIR_W-1:0] fifo_tail;
   logic             fifo_full;
   logic             fifo_empty;
   logic             press_ok;
   logic             pop;
   logic             drop;

   assign btn   = {up, down, left, right};
   assign press = btn & ~btn_q;

   // Button history tracks levels even in reset so a held key never fires.
   always_ff @(posedge clk) begin
      btn_q <= btn;
   end

   // Pick the single highest-priority new press; the others are discarded.
   always_comb begin
      press_dir = DIR_IDLE;
      if (press[3])      press_dir = DIR_UP;
      else if (press[2]) press_dir = DIR_DOWN;
      else if (press[1]) press_dir = DIR_LEFT;
      else if (press[0]) press_dir = DIR_RIGHT;
   end

   // Turns are judged against the last pending turn, not the applied one.
   assign ref_dir  = fifo_empty ? direction : fifo_tail;
   assign press_ok = (press_dir != DIR_IDLE) && (press_dir != ref_dir) &&
                     (press_dir != dir_opposite(ref_dir));
   assign pop      = tick && !fifo_empty;
   assign drop     = press_ok && fifo_full && !pop;

   snake_dir_fifo #(
      .WIDTH (DIR_W),
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (press_ok),
      .pop   (pop),
      .din   (press_dir),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (queue_count),
      .head  (fifo_head),
      .tail  (fifo_tail)
   );

   // Apply one queued turn per tick and raise the one-cycle status pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         direction   <= DIR_IDLE;
         dir_changed <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         dir_changed <= pop;
         overflow    <= drop;
         if (pop) direction <= fifo_head;
      end
   end

endmodule

// File: tb/tb_snake_dir_queue.sv
// tb/tb_snake_dir_queue.sv - self-checking bench for snake_dir_queue
module tb_snake_dir_queue;

   localparam int DEPTH = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
   logic       tick = 1'b0;
   logic [2:0] direction;
   logic       dir_changed;
   logic [1:0] queue_count;
   logic       overflow;

   int total = 0;
   int bad   = 0;

   int       m_dir;
   int       m_q[$];
   bit [3:0] m_prev;
   bit       m_changed;
   bit       m_ovf;

   snake_dir_queue #(.QUEUE_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset       (reset),
      .up          (up),
      .down        (down),
      .left        (left),
      .right       (right),
      .tick        (tick),
      .direction   (direction),
      .dir_changed (dir_changed),
      .queue_count (queue_count),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   function automatic int opp(input int d);
      if (d == 0) return 0;
      return (d % 2 == 1) ? d + 1 : d - 1;
   endfunction

   task automatic model_step(input bit [3:0] b, input bit t, input bit rst);
      bit [3:0] pr;
      int       pd;
      int       rd;
      bit       ok;
      bit       popped;
      if (rst) begin
         m_q.delete();
         m_dir = 0;
         m_changed = 0;
         m_ovf = 0;
      end else begin
         pr = b & ~m_prev;
         pd = 0;
         for (int i = 3; i >= 0; i--)
            if (pd == 0 && pr[i]) pd = 4 - i;
         rd = (m_q.size() > 0) ? m_q[$] : m_dir;
         ok = (pd != 0) && (pd != rd) && (pd != opp(rd));
         popped = t && (m_q.size() > 0);
         m_changed = popped;
         m_ovf = 0;
         if (popped) m_dir = m_q.pop_front();
         if (ok) begin
            if (m_q.size() < DEPTH) m_q.push_back(pd);
            else m_ovf = 1;
         end
      end
      m_prev = b;
   endtask

   task automatic check_val(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_model();
      check_val("direction", int'(direction), m_dir);
      check_val("dir_changed", int'(dir_changed), int'(m_changed));
      check_val("queue_count", int'(queue_count), m_q.size());
      check_val("overflow", int'(overflow), int'(m_ovf));
   endtask

   task automatic cyc(input bit [3:0] b, input bit t = 0, input bit rst = 0);
      {up, down, left, right} = b;
      tick  = t;
      reset = rst;
      @(posedge clk);
      model_step(b, t, rst);
      #1;
      check_model();
   endtask

   initial begin
      // Scenario 1: up held through reset gives no press
      cyc(4'b1000, 0, 1);
      cyc(4'b1000, 0, 1);
      check_val("rst_dir", int'(direction), 0);
      check_val("rst_count", int'(queue_count), 0);
      cyc(4'b1000);
      cyc(4'b0000);
      check_val("s1_held_count", int'(queue_count), 0);
      check_val("s1_held_dir", int'(direction), 0);
      cyc(4'b0001);
      check_val("s1_right_count", int'(queue_count), 1);

      // Scenario 2: press up then tick
      cyc(4'b0000, 0, 1);
      cyc(4'b0000);
      cyc(4'b1000);
      cyc(4'b0000, 1);
      check_val("s2_dir", int'(direction), 1);
      check_val("s2_changed", int'(dir_changed), 1);
      cyc(4'b0000);
      check_val("s2_changed_off", int'(dir_changed), 0);

      // Scenario 3: left then down inside one tick window
      cyc(4'b0010);
      cyc(4'b0000);
      cyc(4'b0100);
      cyc(4'b0000);
      check_val("s3_count", int'(queue_count), 2);
      cyc(4'b0000, 1);
      check_val("s3_dir_left", int'(direction), 3);
      cyc(4'b0000, 1);
      check_val("s3_dir_down", int'(direction), 2);

      // Scenario 4: heading right rejects reverse and duplicate
      cyc(4'b0001);
      cyc(4'b0000, 1);
      check_val("s4_dir_right", int'(direction), 4);
      cyc(4'b0010);
      check_val("s4_reverse", int'(queue_count), 0);
      cyc(4'b0000);
      cyc(4'b0001);
      check_val("s4_duplicate", int'(queue_count), 0);

      // Scenario 5: overflow then push on a full queue during a tick
      cyc(4'b0000, 0, 1);
      cyc(4'b1000);
      cyc(4'b0000, 1);
      cyc(4'b0010);
      cyc(4'b0000);
      cyc(4'b0100);
      cyc(4'b0000);
      cyc(4'b0001);
      check_val("s5_overflow", int'(overflow), 1);
      check_val("s5_count_full", int'(queue_count), 2);
      cyc(4'b0000);
      check_val("s5_overflow_off", int'(overflow), 0);
      cyc(4'b0001, 1);
      check_val("s5_push_pop_count", int'(queue_count), 2);
      check_val("s5_push_pop_ovf", int'(overflow), 0);
      check_val("s5_push_pop_dir", int'(direction), 3);

      // Scenario 6: simultaneous edges, then tick on empty queue
      cyc(4'b0000, 0, 1);
      cyc(4'b0000);
      cyc(4'b1010);
      check_val("s6_count", int'(queue_count), 1);
      cyc(4'b0000, 1);
      check_val("s6_dir_up", int'(direction), 1);
      cyc(4'b0000, 1);
      check_val("s6_empty_tick", int'(dir_changed), 0);

      // Randomized traffic against the reference model
      for (int n = 0; n < 3000; n++) begin
         bit [3:0] b;
         b = 4'($urandom) & 4'($urandom);
         cyc(b, $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
